vmem_leak_seq: RTL
==================

Name: vmem_leak_seq

Overview:
- Sequential, parametrised successor to the combinational membrane-leak datapath.
- Computes the exact leak VmemOut = Vmem + ((Vrest - Vmem) * DeltaT) / Taumem with a bit-serial restoring divider. It does not use an approximate reciprocal.
- Adds a valid/ready handshake, a neuron-ID tag, a per-request bypass mode, divide-by-zero detection and optional saturation.
- Sits between the neuron-state memory read port and the threshold/spike unit, and processes one neuron at a time.

Parameters:
- INTEGER_WIDTH, 32: integer bits of Vmem; width of Vrest and Taumem.
- DATA_WIDTH_FRAC, 32: fractional bits of Vmem.
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC: full Vmem width, signed fixed point.
- DELTAT_WIDTH, 4: DeltaT width. DeltaT is an unsigned fraction, value DeltaT/2^DELTAT_WIDTH.
- NEURON_ID_WIDTH, 10: width of the tag carried with each request.
- SATURATE, 0: 1 = clamp V1 to the signed DATA_WIDTH range instead of wrapping.

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- InValid  in  1  request valid
- InReady  out  1  block can accept a request
- InNeuronID  in  NEURON_ID_WIDTH  tag
- InBypass  in  1  1 = no leak, pass Vmem through
- Vrest  in  INTEGER_WIDTH  signed integer rest potential
- Vmem  in  DATA_WIDTH  signed fixed point
- DeltaT  in  DELTAT_WIDTH  unsigned fraction
- Taumem  in  INTEGER_WIDTH  signed integer time constant
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts the result
- OutNeuronID  out  NEURON_ID_WIDTH  tag of the result
- VmemOut  out  DATA_WIDTH  updated Vmem
- DivByZero  out  1  result produced with Taumem <= 0
- Busy  out  1  state != IDLE

Behaviour:
- Reset (Reset=0, asynchronous, any state, including mid-division):
  - state = IDLE; counter = 0.
  - OutValid = 0, VmemOut = 0, OutNeuronID = 0, DivByZero = 0.
  - InReady = 1 once Reset is released.
- States: IDLE, MULT, DIV, DONE.
- InReady = (state == IDLE). No request is accepted in any other state, so throughput is one request per (latency + 1) cycles.
- IDLE: on InValid, register all inputs and the tag. Then:
  - If InBypass = 1: VmemOut <= Vmem, DivByZero <= 0, go to DONE.
  - Else if Taumem <= 0: VmemOut <= Vmem, DivByZero <= 1, go to DONE.
  - Else go to MULT.
  - Bypass has priority over divide-by-zero.
- MULT (1 cycle):
  - V1 = {Vrest, DATA_WIDTH_FRAC zeros} - Vmem.
    - SATURATE = 0: V1 wraps to DATA_WIDTH bits.
    - SATURATE = 1: V1 is computed at DATA_WIDTH+1 bits and clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - M = (V1 * DeltaT) >>> DELTAT_WIDTH, arithmetic shift, DATA_WIDTH bits.
  - Store sign(M) and |M|. For M = most-negative, |M| is taken as an unsigned DATA_WIDTH-bit value.
  - Load the divider: remainder = 0, counter = DATA_WIDTH - 1. Go to DIV.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first.
  - Dividend: |M|, unsigned. Divisor: Taumem, positive integer, zero-extended to DATA_WIDTH+1 bits.
  - Exactly DATA_WIDTH cycles.
  - On the cycle with counter == 0:
    - Q = sign ? -quotient : quotient. This truncates toward zero.
    - VmemOut <= Vmem_reg + Q, wrapping. The add cannot exceed the segment between Vmem and Vrest unless V1 wrapped.
    - Go to DONE.
- DONE:
  - OutValid = 1; VmemOut, OutNeuronID and DivByZero are held stable.
  - On OutReady = 1, go to IDLE; OutValid falls on the next cycle.
  - OutValid stays high until accepted. The result is never dropped or changed while waiting.
- Latency, counted from the acceptance edge to the first cycle with OutValid high:
  - Divide path: DATA_WIDTH + 2 edges (1 MULT, DATA_WIDTH DIV, 1 transition to DONE).
  - Bypass and divide-by-zero paths: 1 edge.
- Inputs are sampled only at acceptance. Changes on input ports after that have no effect.

Decomposition:
- Package vmem_leak_pkg holds:
  - State enum: IDLE, MULT, DIV, DONE.
  - Default widths.
  - Function sat_sub for the SATURATE clamp.
- One sub-module: seq_restoring_divider.
  - Unsigned, parametrised width.
  - Ports: start, dividend, divisor, done, quotient.
  - Owns the counter and the remainder register.
  - Reusable by the synaptic-current decay unit.

Test Plan:
All values below use default parameters; raw values are in LSBs of Q32.32.
- Nominal divide: Vrest=-70, Vmem=-60.0, DeltaT=8 (0.5), Taumem=5, tag 0x2A.
  - Expected: VmemOut=-61.0, OutNeuronID=0x2A, DivByZero=0.
  - OutValid high exactly 66 edges after acceptance.
- Truncation toward zero: Vrest=0, DeltaT=15, Taumem=4.
  - Vmem raw -48 -> VmemOut raw -37.
  - Vmem raw +48 -> VmemOut raw +37.
- Bypass and divide-by-zero paths, each with latency 1:
  - InBypass=1, Vmem=12.5 -> VmemOut=12.5, DivByZero=0.
  - InBypass=0, Taumem=0 -> VmemOut=Vmem, DivByZero=1.
  - Taumem=-3 -> VmemOut=Vmem, DivByZero=1.
- Backpressure: hold OutReady=0 for 20 cycles after OutValid.
  - OutValid, VmemOut and OutNeuronID remain stable.
  - InReady stays 0; a new InValid is ignored until the cycle after OutReady=1.
- Saturation: Vrest=100, Vmem=most-negative, DeltaT=15, Taumem=1.
  - SATURATE=1: V1 is clamped to max positive, and the result equals Vmem + ((2^63-1)*15>>>4).
  - SATURATE=0: the wrapped result matches the reference model.
- Reset mid-DIV: assert Reset=0 at DIV cycle 30.
  - Immediately: OutValid=0, VmemOut=0, Busy=0.
  - After release, the next request completes with the correct result and full latency.

Source files
------------

// File: rtl/vmem_leak_pkg.sv
// Shared types, default widths and the saturating subtract for the membrane-leak datapath.
package vmem_leak_pkg;

    localparam int unsigned INTEGER_WIDTH_DEF   = 32;
    localparam int unsigned DATA_WIDTH_FRAC_DEF = 32;
    localparam int unsigned DELTAT_WIDTH_DEF    = 4;
    localparam int unsigned NEURON_ID_WIDTH_DEF = 10;
    // Working width of sat_sub; holds any DATA_WIDTH+1 difference up to 127 bits.
    localparam int unsigned SAT_W               = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    // a - b, clamped to the signed range of a w-bit word (operands arrive sign-extended).
    function automatic logic [SAT_W-1:0] sat_sub(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] diff;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one  = SAT_W'(1);
        diff = a - b;
        hi   = (one <<< (w - 1)) - one;
        lo   = -hi - one;
        if (diff > hi) begin
            return hi;
        end
        if (diff < lo) begin
            return lo;
        end
        return diff;
    endfunction

endpackage

// File: rtl/vmem_leak_seq_divider.sv
// Unsigned bit-serial restoring divider; one quotient bit per cycle, MSB first.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dq_step;

    // One restoring step: dq_q shifts dividend bits out of the top and quotient bits in.
    always_comb begin
        shifted  = {rem_q, dq_q[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvs_q});
        rem_step = fits ? WIDTH'(shifted - {1'b0, dvs_q}) : WIDTH'(shifted);
        dq_step  = {dq_q[WIDTH-2:0], fits};
    end

    // Quotient is complete during the cycle done is high.
    assign done     = active_q && (cnt_q == '0);
    assign quotient = dq_step;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dq_d     = dq_q;
        dvs_d    = dvs_q;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = CNT_W'(WIDTH - 1);
            rem_d    = '0;
            dq_d     = dividend;
            dvs_d    = divisor;
        end else if (active_q) begin
            rem_d = rem_step;
            dq_d  = dq_step;
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dq_q     <= dq_d;
            dvs_q    <= dvs_d;
        end
    end

endmodule

// File: rtl/vmem_leak_seq.sv
// Exact membrane leak Vmem + ((Vrest - Vmem) * DeltaT) / Taumem, one neuron per request.
module vmem_leak_seq
    import vmem_leak_pkg::*;
#(
    parameter int unsigned INTEGER_WIDTH   = INTEGER_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH_FRAC = DATA_WIDTH_FRAC_DEF,
    parameter int unsigned DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int unsigned DELTAT_WIDTH    = DELTAT_WIDTH_DEF,
    parameter int unsigned NEURON_ID_WIDTH = NEURON_ID_WIDTH_DEF,
    parameter int unsigned SATURATE        = 0
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [NEURON_ID_WIDTH-1:0] InNeuronID,
    input  logic                       InBypass,
    input  logic [INTEGER_WIDTH-1:0]   Vrest,
    input  logic [DATA_WIDTH-1:0]      Vmem,
    input  logic [DELTAT_WIDTH-1:0]    DeltaT,
    input  logic [INTEGER_WIDTH-1:0]   Taumem,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [NEURON_ID_WIDTH-1:0] OutNeuronID,
    output logic [DATA_WIDTH-1:0]      VmemOut,
    output logic                       DivByZero,
    output logic                       Busy
);

    localparam int unsigned PW = DATA_WIDTH + DELTAT_WIDTH + 1;

    state_e                     state_q, state_d;
    logic [INTEGER_WIDTH-1:0]   vrest_q, vrest_d;
    logic [DATA_WIDTH-1:0]      vmem_q, vmem_d;
    logic [DELTAT_WIDTH-1:0]    dt_q, dt_d;
    logic [INTEGER_WIDTH-1:0]   tau_q, tau_d;
    logic                       sign_q, sign_d;
    logic [DATA_WIDTH-1:0]      vout_q, vout_d;
    logic [NEURON_ID_WIDTH-1:0] id_q, id_d;
    logic                       dbz_q, dbz_d;
    logic                       in_ready_q, in_ready_d;
    logic                       out_valid_q, out_valid_d;
    logic                       busy_q, busy_d;

    logic [DATA_WIDTH-1:0]        vrest_fix;
    logic [DATA_WIDTH-1:0]        v1_wrap;
    logic [DATA_WIDTH-1:0]        v1_sat;
    logic signed [DATA_WIDTH-1:0] v1;
    logic signed [PW-1:0]         v1_ext;
    logic signed [PW-1:0]         dt_ext;
    logic signed [PW-1:0]         prod;
    logic signed [DATA_WIDTH-1:0] m;
    logic                         m_neg;
    logic [DATA_WIDTH-1:0]        m_mag;
    logic [DATA_WIDTH-1:0]        q_signed;

    logic                  div_start_c;
    logic                  div_done;
    logic [DATA_WIDTH-1:0] div_quotient;

    // Scaled difference M and its magnitude, evaluated from the registered request.
    always_comb begin
        vrest_fix = {vrest_q, {DATA_WIDTH_FRAC{1'b0}}};
        v1_wrap   = vrest_fix - vmem_q;
        v1_sat    = DATA_WIDTH'(sat_sub(SAT_W'($signed(vrest_fix)), SAT_W'($signed(vmem_q)),
                                        DATA_WIDTH));
        v1        = (SATURATE != 0) ? v1_sat : v1_wrap;
        v1_ext    = PW'(v1);
        dt_ext    = PW'({1'b0, dt_q});
        prod      = v1_ext * dt_ext;
        m         = DATA_WIDTH'(prod >>> DELTAT_WIDTH);
        m_neg     = m[DATA_WIDTH-1];
        m_mag     = m_neg ? (~m + DATA_WIDTH'(1)) : m;
        q_signed  = sign_q ? (~div_quotient + DATA_WIDTH'(1)) : div_quotient;
    end

    assign div_start_c = (state_q == MULT);

    seq_restoring_divider #(
        .WIDTH (DATA_WIDTH)
    ) u_div (
        .clk      (Clock),
        .rst_n    (Reset),
        .start    (div_start_c),
        .dividend (m_mag),
        .divisor  (DATA_WIDTH'(tau_q)),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_comb begin
        state_d  = state_q;
        vrest_d  = vrest_q;
        vmem_d   = vmem_q;
        dt_d     = dt_q;
        tau_d    = tau_q;
        sign_d   = sign_q;
        vout_d   = vout_q;
        id_d     = id_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    vrest_d = Vrest;
                    vmem_d  = Vmem;
                    dt_d    = DeltaT;
                    tau_d   = Taumem;
                    id_d    = InNeuronID;
                    // Bypass wins over the Taumem <= 0 check.
                    if (InBypass) begin
                        vout_d  = Vmem;
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end else if (Taumem[INTEGER_WIDTH-1] || (Taumem == '0)) begin
                        vout_d  = Vmem;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = MULT;
                    end
                end
            end
            MULT: begin
                sign_d  = m_neg;
                state_d = DIV;
            end
            DIV: begin
                if (div_done) begin
                    vout_d  = vmem_q + q_signed;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            vrest_q     <= '0;
            vmem_q      <= '0;
            dt_q        <= '0;
            tau_q       <= '0;
            sign_q      <= 1'b0;
            vout_q      <= '0;
            id_q        <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vrest_q     <= vrest_d;
            vmem_q      <= vmem_d;
            dt_q        <= dt_d;
            tau_q       <= tau_d;
            sign_q      <= sign_d;
            vout_q      <= vout_d;
            id_q        <= id_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign InReady     = in_ready_q;
    assign OutValid    = out_valid_q;
    assign OutNeuronID = id_q;
    assign VmemOut     = vout_q;
    assign DivByZero   = dbz_q;
    assign Busy        = busy_q;

endmodule
